// File: rtl/ddr_arb_pkg.sv
// Shared types and AXI constants for the DDR read/write arbiters.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } arb_state_e;

  localparam logic [2:0] AXSIZE_8B  = 3'd3;
  localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to prio_i.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = prio_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Shares one AXI4 read master (AR/R) between two requesters, one burst in flight,
// routing R beats back to the burst owner and flagging response/length errors.
module ddr_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] REQ0_ARADDR,
  input  logic [7:0]        REQ0_ARLEN,
  input  logic              REQ0_ARVALID,
  output logic              REQ0_ARREADY,
  output logic [DATA_W-1:0] REQ0_RDATA,
  output logic              REQ0_RLAST,
  output logic              REQ0_RVALID,
  input  logic              REQ0_RREADY,
  input  logic [ADDR_W-1:0] REQ1_ARADDR,
  input  logic [7:0]        REQ1_ARLEN,
  input  logic              REQ1_ARVALID,
  output logic              REQ1_ARREADY,
  output logic [DATA_W-1:0] REQ1_RDATA,
  output logic              REQ1_RLAST,
  output logic              REQ1_RVALID,
  input  logic              REQ1_RREADY,
  output logic              M_AXI_ARID,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic              M_AXI_RID,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  input  logic              ERR_CLR,
  output logic              ERR_RESP,
  output logic              ERR_LEN
);

  import ddr_arb_pkg::*;

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              prio_q, prio_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_resp_q, err_resp_d;
  logic              err_len_q, err_len_d;

  logic [1:0] req, gnt;
  logic       in_idle, in_data, sel_rready, r_hs, set_resp, set_len;

  assign req = {REQ1_ARVALID, REQ0_ARVALID};

  rr_arb2 u_rr_arb2 (
    .req_i  (req),
    .prio_i (prio_q),
    .gnt_o  (gnt)
  );

  assign in_idle    = (state_q == StIdle);
  assign in_data    = (state_q == StData);
  assign sel_rready = grant_q ? REQ1_RREADY : REQ0_RREADY;
  assign r_hs       = in_data & M_AXI_RVALID & sel_rready;

  // Grant is combinational in idle so the command handshake lands in the same cycle.
  assign REQ0_ARREADY = in_idle & gnt[0];
  assign REQ1_ARREADY = in_idle & gnt[1];

  assign M_AXI_ARID    = grant_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = AXSIZE_8B;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARVALID = (state_q == StAddr);
  assign M_AXI_RREADY  = in_data & sel_rready;

  assign REQ0_RVALID = in_data & ~grant_q & M_AXI_RVALID;
  assign REQ1_RVALID = in_data & grant_q & M_AXI_RVALID;
  assign REQ0_RDATA  = in_data ? M_AXI_RDATA : '0;
  assign REQ1_RDATA  = in_data ? M_AXI_RDATA : '0;
  assign REQ0_RLAST  = in_data & M_AXI_RLAST;
  assign REQ1_RLAST  = in_data & M_AXI_RLAST;

  assign ERR_RESP = err_resp_q;
  assign ERR_LEN  = err_len_q;

  assign set_resp = r_hs & (M_AXI_RRESP != 2'b00);
  assign set_len  = r_hs & ((M_AXI_RLAST & (cnt_q != len_q)) | (M_AXI_RID != grant_q));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d = gnt[1];
          addr_d  = gnt[1] ? REQ1_ARADDR : REQ0_ARADDR;
          len_d   = gnt[1] ? REQ1_ARLEN : REQ0_ARLEN;
          cnt_d   = '0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (M_AXI_ARREADY) begin
          state_d = StData;
        end
      end
      StData: begin
        if (r_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (M_AXI_RLAST) begin
            prio_d  = ~grant_q;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  assign err_resp_d = (err_resp_q & ~ERR_CLR) | set_resp;
  assign err_len_d  = (err_len_q & ~ERR_CLR) | set_len;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      prio_q     <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_resp_q <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      err_resp_q <= err_resp_d;
      err_len_q  <= err_len_d;
    end
  end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Scoreboard bench for ddr_rd_arbiter: directed stimulus pushes expected AR commands and
// R beats; a negedge monitor pops and compares whenever the DUT presents a handshake.
module tb_ddr_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req0_araddr, req1_araddr;
  logic [7:0]  req0_arlen, req1_arlen;
  logic        req0_arvalid, req1_arvalid, req0_arready, req1_arready;
  logic [63:0] req0_rdata, req1_rdata;
  logic        req0_rlast, req1_rlast, req0_rvalid, req1_rvalid;
  logic        req0_rready, req1_rready;
  logic        m_arid, m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rid, m_rlast, m_rvalid, m_rready;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        err_clr, err_resp, err_len;

  always #5 clk = ~clk;

  ddr_rd_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
    .ACLK(clk), .ARESET(rst),
    .REQ0_ARADDR(req0_araddr), .REQ0_ARLEN(req0_arlen), .REQ0_ARVALID(req0_arvalid),
    .REQ0_ARREADY(req0_arready), .REQ0_RDATA(req0_rdata), .REQ0_RLAST(req0_rlast),
    .REQ0_RVALID(req0_rvalid), .REQ0_RREADY(req0_rready),
    .REQ1_ARADDR(req1_araddr), .REQ1_ARLEN(req1_arlen), .REQ1_ARVALID(req1_arvalid),
    .REQ1_ARREADY(req1_arready), .REQ1_RDATA(req1_rdata), .REQ1_RLAST(req1_rlast),
    .REQ1_RVALID(req1_rvalid), .REQ1_RREADY(req1_rready),
    .M_AXI_ARID(m_arid), .M_AXI_ARADDR(m_araddr), .M_AXI_ARLEN(m_arlen),
    .M_AXI_ARSIZE(m_arsize), .M_AXI_ARBURST(m_arburst), .M_AXI_ARVALID(m_arvalid),
    .M_AXI_ARREADY(m_arready), .M_AXI_RID(m_rid), .M_AXI_RDATA(m_rdata),
    .M_AXI_RRESP(m_rresp), .M_AXI_RLAST(m_rlast), .M_AXI_RVALID(m_rvalid),
    .M_AXI_RREADY(m_rready), .ERR_CLR(err_clr), .ERR_RESP(err_resp), .ERR_LEN(err_len)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  ar_t   q_ar[$];
  beat_t q_b0[$];
  beat_t q_b1[$];
  int    tests = 0;
  int    fails = 0;
  int    cur_req = 2;
  int    beats1_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got nothing, expected an entry/event", name);
  endtask

  // Monitor: pops the scoreboard on every DUT-presented handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_arvalid && m_arready) begin
        if (q_ar.size() == 0) note_fail("ar_unexpected");
        else begin
          ar_t e;
          e = q_ar.pop_front();
          check("ar_id", {63'd0, m_arid}, {63'd0, e.id});
          check("ar_addr", {32'd0, m_araddr}, {32'd0, e.addr});
          check("ar_len", {56'd0, m_arlen}, {56'd0, e.len});
          check("ar_size_burst", {59'd0, m_arsize, m_arburst}, {59'd0, 3'd3, 2'b01});
        end
      end
      if (m_rvalid && cur_req < 2) begin
        check("req0_rvalid", {63'd0, req0_rvalid}, {63'd0, (cur_req == 0)});
        check("req1_rvalid", {63'd0, req1_rvalid}, {63'd0, (cur_req == 1)});
        check("m_rready_mirror", {63'd0, m_rready},
              {63'd0, (cur_req == 0) ? req0_rready : req1_rready});
      end
      if (req0_rvalid && req0_rready) begin
        if (q_b0.size() == 0) note_fail("r0_unexpected");
        else begin
          beat_t b;
          b = q_b0.pop_front();
          check("r0_data", req0_rdata, b.data);
          check("r0_last", {63'd0, req0_rlast}, {63'd0, b.last});
        end
      end
      if (req1_rvalid && req1_rready) begin
        beats1_seen++;
        if (q_b1.size() == 0) note_fail("r1_unexpected");
        else begin
          beat_t b;
          b = q_b1.pop_front();
          check("r1_data", req1_rdata, b.data);
          check("r1_last", {63'd0, req1_rlast}, {63'd0, b.last});
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int r, input logic [31:0] a, input logic [7:0] l);
    cur_req = r;
    q_ar.push_back('{id: r[0], addr: a, len: l});
    if (r == 0) begin req0_araddr = a; req0_arlen = l; req0_arvalid = 1'b1; end
    else begin req1_araddr = a; req1_arlen = l; req1_arvalid = 1'b1; end
    @(negedge clk);
    check("req_arready", {63'd0, (r == 0) ? req0_arready : req1_arready}, 64'd1);
    @(posedge clk);
    #1;
    req0_arvalid = 1'b0;
    req1_arvalid = 1'b0;
  endtask

  task automatic wait_ar();
    int n;
    n = 0;
    @(negedge clk);
    while (!(m_arvalid && m_arready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) note_fail("ar_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic id, input logic [63:0] d, input logic last,
                           input logic [1:0] resp);
    logic ok;
    int   n;
    if (cur_req == 0) q_b0.push_back('{data: d, last: last});
    else if (cur_req == 1) q_b1.push_back('{data: d, last: last});
    m_rvalid = 1'b1; m_rid = id; m_rdata = d; m_rlast = last; m_rresp = resp;
    n = 0;
    do begin
      @(negedge clk);
      ok = m_rready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) note_fail("r_timeout");
    if (last) begin m_rvalid = 1'b0; m_rlast = 1'b0; end
    m_rresp = 2'b00;
  endtask

  initial begin
    logic done;
    rst = 1'b1;
    req0_araddr = '0; req0_arlen = '0; req0_arvalid = 1'b0; req0_rready = 1'b1;
    req1_araddr = '0; req1_arlen = '0; req1_arvalid = 1'b0; req1_rready = 1'b1;
    m_arready = 1'b1; m_rid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    m_rvalid = 1'b0; err_clr = 1'b0;
    cyc(3);
    check("rst_arvalid_rready", {62'd0, m_arvalid, m_rready}, 64'd0);
    check("rst_ar_fields", {23'd0, m_arid, m_araddr, m_arlen}, 64'd0);
    check("rst_const", {59'd0, m_arsize, m_arburst}, {59'd0, 3'd3, 2'b01});
    check("rst_flags", {60'd0, err_resp, err_len, req0_arready, req1_arready}, 64'd0);
    rst = 1'b0;
    cyc(2);

    // Fairness from reset: both hold ARVALID for four single-beat bursts.
    req0_araddr = 32'h100; req0_arlen = 8'd0; req1_araddr = 32'h200; req1_arlen = 8'd0;
    req0_arvalid = 1'b1; req1_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_ar.push_back('{id: i[0], addr: (i[0] ? 32'h200 : 32'h100), len: 8'd0});
    end
    for (int i = 0; i < 4; i++) begin
      cur_req = i % 2;
      wait_ar();
      send_beat(i[0], 64'hF000 + 64'(i), 1'b1, 2'b00);
    end
    req0_arvalid = 1'b0; req1_arvalid = 1'b0;
    cyc(2);

    // Single burst from requester 0.
    issue(0, 32'h1000, 8'd3);
    wait_ar();
    for (int i = 0; i < 4; i++) send_beat(1'b0, 64'h1111_0000 + 64'(i), (i == 3), 2'b00);
    check("single_flags", {62'd0, err_resp, err_len}, 64'd0);
    cyc(2);

    // AR back-pressure for 20 cycles, with requester 1 knocking meanwhile.
    m_arready = 1'b0;
    issue(0, 32'h2000, 8'd1);
    req1_araddr = 32'h2100; req1_arlen = 8'd5; req1_arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_arvalid", {63'd0, m_arvalid}, 64'd1);
      check("bp_ar_hold", {24'd0, m_araddr, m_arlen}, {24'd0, 32'h2000, 8'd1});
      check("bp_req_arready", {62'd0, req0_arready, req1_arready}, 64'd0);
    end
    @(posedge clk);
    #1;
    req1_arvalid = 1'b0;
    m_arready = 1'b1;
    wait_ar();
    send_beat(1'b0, 64'h2222_0000, 1'b0, 2'b00);
    send_beat(1'b0, 64'h2222_0001, 1'b1, 2'b00);
    cyc(2);

    // R back-pressure: requester 1 toggles RREADY during an 8-beat burst.
    issue(1, 32'h3000, 8'd7);
    wait_ar();
    beats1_seen = 0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(1'b1, 64'hA0 + 64'(i), (i == 7), 2'b00);
        done = 1'b1;
      end
      begin
        while (!done) begin
          req1_rready = ~req1_rready;
          @(posedge clk);
          #1;
        end
      end
    join
    req1_rready = 1'b1;
    check("rbp_beat_count", 64'(beats1_seen), 64'd8);
    cyc(2);

    // RRESP error on beat 2, sticky until ERR_CLR.
    issue(0, 32'h5000, 8'd3);
    wait_ar();
    send_beat(1'b0, 64'h5000, 1'b0, 2'b00);
    check("err_resp_before", {63'd0, err_resp}, 64'd0);
    send_beat(1'b0, 64'h5001, 1'b0, 2'b10);
    check("err_resp_set", {63'd0, err_resp}, 64'd1);
    send_beat(1'b0, 64'h5002, 1'b0, 2'b00);
    send_beat(1'b0, 64'h5003, 1'b1, 2'b00);
    check("err_resp_sticky", {62'd0, err_resp, err_len}, 64'd2);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    check("err_resp_cleared", {63'd0, err_resp}, 64'd0);

    // Early RLAST on beat 3 of an 8-beat burst.
    issue(1, 32'h7000, 8'd7);
    wait_ar();
    send_beat(1'b1, 64'h7000, 1'b0, 2'b00);
    send_beat(1'b1, 64'h7001, 1'b0, 2'b00);
    send_beat(1'b1, 64'h7002, 1'b1, 2'b00);
    check("err_len_set", {62'd0, err_resp, err_len}, 64'd1);
    issue(1, 32'h7100, 8'd0);
    wait_ar();
    send_beat(1'b1, 64'h7100, 1'b1, 2'b00);
    check("err_len_sticky", {63'd0, err_len}, 64'd1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    check("err_len_cleared", {63'd0, err_len}, 64'd0);
    cyc(2);

    // Reset in the middle of a DATA phase.
    issue(0, 32'h4000, 8'd7);
    wait_ar();
    send_beat(1'b0, 64'h4000, 1'b0, 2'b00);
    send_beat(1'b0, 64'h4001, 1'b0, 2'b00);
    cur_req = 2;
    rst = 1'b1;
    #1;
    check("arst_r_path", {62'd0, req0_rvalid, m_rready}, 64'd0);
    check("arst_ar", {22'd0, m_arvalid, m_arid, m_araddr, m_arlen}, 64'd0);
    check("arst_const_flags", {57'd0, m_arsize, m_arburst, err_resp, err_len},
          {57'd0, 3'd3, 2'b01, 2'b00});
    m_rvalid = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    req0_araddr = 32'h6000; req0_arlen = 8'd0; req1_araddr = 32'h6100; req1_arlen = 8'd0;
    req0_arvalid = 1'b1; req1_arvalid = 1'b1;
    cur_req = 0;
    q_ar.push_back('{id: 1'b0, addr: 32'h6000, len: 8'd0});
    @(negedge clk);
    check("post_rst_winner", {62'd0, req1_arready, req0_arready}, 64'd1);
    @(posedge clk);
    #1;
    req0_arvalid = 1'b0; req1_arvalid = 1'b0;
    wait_ar();
    send_beat(1'b0, 64'h6000, 1'b1, 2'b00);
    cyc(3);

    check("sb_ar_empty", 64'(q_ar.size()), 64'd0);
    check("sb_r0_empty", 64'(q_b0.size()), 64'd0);
    check("sb_r1_empty", 64'(q_b1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
